wb_stage: RTL and testbench

Writeback pipeline stage of the five-stage MIPS core, sitting directly upstream of the register file write port. It accepts one retiring instruction per cycle from the memory stage over a valid/allowin handshake and registers it. For loads it aligns and sign/zero-extends the memory word. It drives the register file's byte-enable write port (`we[3:0]`, `waddr`, `wdata`) and a bypass port back to decode.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_load_align.sv | 67 ++++++
 rtl/wb_stage.sv | 109 ++++++++++
 tb/tb_wb_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load-op encodings and write masks.
// Optional feature macro: WB_UNALIGNED_LOAD_EN (LWL/LWR support).
package wb_pkg;

  typedef enum logic [2:0] {
    LW   = 3'd0,
    LB   = 3'd1,
    LBU  = 3'd2,
    LH   = 3'd3,
    LHU  = 3'd4,
    LWL  = 3'd5,
    LWR  = 3'd6,
    NONE = 3'd7
  } load_op_e;

  localparam logic [3:0] MASK_FULL = 4'b1111;
  localparam logic [3:0] MASK_NONE = 4'b0000;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load aligner: picks and extends the loaded byte/half/word and the
// byte-enable mask. LWL/LWR are only decoded when WB_UNALIGNED_LOAD_EN is defined.
module wb_load_align
  import wb_pkg::*;
(
  input  logic [2:0]  i_load_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_alu_result,
  output logic [3:0]  o_byte_mask,
  output logic [31:0] o_wdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
  end

  // Halfword loads ignore addr_lo[0]; misalignment is trapped before this stage.
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_byte_mask = MASK_FULL;
    o_wdata     = i_alu_result;
    case (load_op_e'(i_load_op))
      LW:  o_wdata = i_rdata;
      LB:  o_wdata = ext8(w_byte, 1'b1);
      LBU: o_wdata = ext8(w_byte, 1'b0);
      LH:  o_wdata = ext16(w_half, 1'b1);
      LHU: o_wdata = ext16(w_half, 1'b0);
`ifdef WB_UNALIGNED_LOAD_EN
      LWL: begin
        case (i_addr_lo)
          2'd0: begin o_byte_mask = 4'b1000; o_wdata = {i_rdata[7:0],  24'h0}; end
          2'd1: begin o_byte_mask = 4'b1100; o_wdata = {i_rdata[15:0], 16'h0}; end
          2'd2: begin o_byte_mask = 4'b1110; o_wdata = {i_rdata[23:0],  8'h0}; end
          default: begin o_byte_mask = 4'b1111; o_wdata = i_rdata; end
        endcase
      end
      LWR: begin
        case (i_addr_lo)
          2'd0: begin o_byte_mask = 4'b1111; o_wdata = i_rdata; end
          2'd1: begin o_byte_mask = 4'b0111; o_wdata = {8'h0,  i_rdata[31:8]};  end
          2'd2: begin o_byte_mask = 4'b0011; o_wdata = {16'h0, i_rdata[31:16]}; end
          default: begin o_byte_mask = 4'b0001; o_wdata = {24'h0, i_rdata[31:24]}; end
        endcase
      end
`else
      LWL, LWR: begin
        o_byte_mask = MASK_NONE;
        o_wdata     = 32'h0;
      end
`endif
      default: o_wdata = i_alu_result;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: registers the retiring instruction, drives the byte-enable
// register-file write port and the decode bypass. Optional: WB_UNALIGNED_LOAD_EN.
module wb_stage
  import wb_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            ms_to_ws_valid,
  output logic            ws_allowin,
  input  logic [PC_W-1:0] ms_pc,
  input  logic            ms_gr_we,
  input  logic [4:0]      ms_dest,
  input  logic [2:0]      ms_load_op,
  input  logic [1:0]      ms_addr_lo,
  input  logic [31:0]     ms_alu_result,
  input  logic [31:0]     ms_mem_rdata,
  input  logic            ws_stall,
  input  logic            ws_flush,
  output logic [3:0]      rf_we,
  output logic [4:0]      rf_waddr,
  output logic [31:0]     rf_wdata,
  output logic            ws_fwd_valid,
  output logic [4:0]      ws_fwd_dest,
  output logic [31:0]     ws_fwd_data,
  output logic            ws_fwd_partial,
  output logic [PC_W-1:0] debug_wb_pc
);

  logic            r_valid;
  logic [PC_W-1:0] r_pc;
  logic            r_gr_we;
  logic [4:0]      r_dest;
  logic [2:0]      r_load_op;
  logic [1:0]      r_addr_lo;
  logic [31:0]     r_alu_result;
  logic [31:0]     r_mem_rdata;

  logic            w_ready_go;
  logic            w_transfer;
  logic            w_dest_live;
  logic            w_commit;
  logic [3:0]      w_mask;
  logic [31:0]     w_wdata;

  assign w_ready_go = !ws_stall;
  assign ws_allowin = !r_valid || w_ready_go;
  // A flush only blocks the incoming transfer; a stalled resident instruction survives.
  assign w_transfer = ms_to_ws_valid && ws_allowin && !ws_flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
    end else if (w_transfer) begin
      r_valid <= 1'b1;
    end else if (w_ready_go) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc         <= '0;
      r_gr_we      <= 1'b0;
      r_dest       <= 5'd0;
      r_load_op    <= 3'd0;
      r_addr_lo    <= 2'd0;
      r_alu_result <= 32'h0;
      r_mem_rdata  <= 32'h0;
    end else if (w_transfer) begin
      r_pc         <= ms_pc;
      r_gr_we      <= ms_gr_we;
      r_dest       <= ms_dest;
      r_load_op    <= ms_load_op;
      r_addr_lo    <= ms_addr_lo;
      r_alu_result <= ms_alu_result;
      r_mem_rdata  <= ms_mem_rdata;
    end
  end

  wb_load_align u_align (
    .i_load_op    (r_load_op),
    .i_addr_lo    (r_addr_lo),
    .i_rdata      (r_mem_rdata),
    .i_alu_result (r_alu_result),
    .o_byte_mask  (w_mask),
    .o_wdata      (w_wdata)
  );

  assign w_dest_live = r_valid && r_gr_we && (r_dest != 5'd0);
  // Strobe only in the cycle the stage releases, so each instruction writes once.
  assign w_commit    = w_dest_live && w_ready_go;

  assign rf_we       = {4{w_commit}} & w_mask;
  assign rf_waddr    = r_dest;
  assign rf_wdata    = w_wdata;
  assign debug_wb_pc = r_pc;

  assign ws_fwd_valid = w_dest_live;
  assign ws_fwd_dest  = r_dest;
  assign ws_fwd_data  = w_wdata;
`ifdef WB_UNALIGNED_LOAD_EN
  assign ws_fwd_partial = w_dest_live && (w_mask != MASK_FULL);
`else
  assign ws_fwd_partial = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, multi-cycle handshake
// sequences, then randomized traffic against a transaction-level reference model.
module tb_wb_stage;

  logic        clk;
  logic        resetn;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [2:0]  ms_load_op;
  logic [1:0]  ms_addr_lo;
  logic [31:0] ms_alu_result;
  logic [31:0] ms_mem_rdata;
  logic        ws_stall;
  logic        ws_flush;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_fwd_valid;
  logic [4:0]  ws_fwd_dest;
  logic [31:0] ws_fwd_data;
  logic        ws_fwd_partial;
  logic [31:0] debug_wb_pc;

  wb_stage #(.PC_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
    .ms_load_op(ms_load_op), .ms_addr_lo(ms_addr_lo),
    .ms_alu_result(ms_alu_result), .ms_mem_rdata(ms_mem_rdata),
    .ws_stall(ws_stall), .ws_flush(ws_flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_fwd_valid(ws_fwd_valid), .ws_fwd_dest(ws_fwd_dest),
    .ws_fwd_data(ws_fwd_data), .ws_fwd_partial(ws_fwd_partial),
    .debug_wb_pc(debug_wb_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  lo;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic        gr_we;
    logic [31:0] pc;
  } ins_t;

  typedef struct {
    ins_t        in;
    logic [3:0]  exp_we;
    logic [31:0] exp_data;
    logic        chk_data;
    logic        exp_fv;
    logic        exp_part;
  } vec_t;

  // Reference: byte/half extraction by shifting and arithmetic sign extension.
  function automatic void ref_load(input ins_t x, output logic [3:0] mask,
                                   output logic [31:0] data, output bit known);
    logic [31:0] b, h;
    logic [3:0]  f;
    f = 4'hF; mask = 4'hF; data = 32'h0; known = 1'b1;
    b = (x.rdata >> (8 * x.lo)) & 32'hFF;
    h = (x.rdata >> (16 * (x.lo / 2))) & 32'hFFFF;
    case (x.op)
      3'd0: data = x.rdata;
      3'd1: data = (b >= 128) ? b - 32'd256 : b;
      3'd2: data = b;
      3'd3: data = (h >= 32768) ? h - 32'd65536 : h;
      3'd4: data = h;
`ifdef WB_UNALIGNED_LOAD_EN
      3'd5: begin mask = f << (3 - x.lo); data = x.rdata << (8 * (3 - x.lo)); end
      3'd6: begin mask = f >> x.lo;       data = x.rdata >> (8 * x.lo); end
`else
      3'd5, 3'd6: begin mask = 4'h0; known = 1'b0; end
`endif
      default: data = x.alu;
    endcase
  endfunction

  task automatic drive(input logic v, input ins_t x);
    ms_to_ws_valid = v;
    ms_load_op = x.op; ms_addr_lo = x.lo; ms_mem_rdata = x.rdata;
    ms_alu_result = x.alu; ms_dest = x.dest; ms_gr_we = x.gr_we; ms_pc = x.pc;
  endtask

  function automatic ins_t mk(input logic [2:0] op, input logic [1:0] lo,
                              input logic [31:0] rd, input logic [31:0] alu,
                              input logic [4:0] dest, input logic we, input logic [31:0] pc);
    ins_t x;
    x.op = op; x.lo = lo; x.rdata = rd; x.alu = alu; x.dest = dest; x.gr_we = we; x.pc = pc;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs[11];
  ins_t idle, a, b;
  ins_t m_cur;
  logic m_valid;

  initial begin
    idle = mk(3'd7, 2'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    resetn = 1'b1; ws_stall = 1'b0; ws_flush = 1'b0;
    drive(1'b0, idle);
    #1 resetn = 1'b0;
    #1;
    chk("rst_allowin", {31'h0, ws_allowin}, 32'h1);
    chk("rst_rf_we", {28'h0, rf_we}, 32'h0);
    chk("rst_waddr", {27'h0, rf_waddr}, 32'h0);
    chk("rst_wdata", rf_wdata, 32'h0);
    chk("rst_fwd", {30'h0, ws_fwd_valid, ws_fwd_partial}, 32'h0);
    chk("rst_pc", debug_wb_pc, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    vecs[0]  = '{mk(3'd7, 2'd0, 32'h0,        32'h12345678, 5'd5, 1'b1, 32'h100), 4'hF, 32'h12345678, 1, 1, 0};
    vecs[1]  = '{mk(3'd1, 2'd3, 32'h80FF7F01, 32'h0,        5'd6, 1'b1, 32'h104), 4'hF, 32'hFFFFFF80, 1, 1, 0};
    vecs[2]  = '{mk(3'd2, 2'd3, 32'h80FF7F01, 32'h0,        5'd6, 1'b1, 32'h108), 4'hF, 32'h00000080, 1, 1, 0};
    vecs[3]  = '{mk(3'd3, 2'd2, 32'h80FF7F01, 32'h0,        5'd7, 1'b1, 32'h10C), 4'hF, 32'hFFFF80FF, 1, 1, 0};
    vecs[4]  = '{mk(3'd4, 2'd3, 32'h80FF7F01, 32'h0,        5'd8, 1'b1, 32'h110), 4'hF, 32'h000080FF, 1, 1, 0};
    vecs[5]  = '{mk(3'd1, 2'd1, 32'h80FF7F01, 32'h0,        5'd9, 1'b1, 32'h114), 4'hF, 32'h0000007F, 1, 1, 0};
    vecs[6]  = '{mk(3'd0, 2'd0, 32'h80FF7F01, 32'h0,        5'd31, 1'b1, 32'h118), 4'hF, 32'h80FF7F01, 1, 1, 0};
    vecs[7]  = '{mk(3'd7, 2'd0, 32'h0,        32'hDEADBEEF, 5'd0, 1'b1, 32'h11C), 4'h0, 32'hDEADBEEF, 1, 0, 0};
    vecs[8]  = '{mk(3'd7, 2'd0, 32'h0,        32'hCAFEF00D, 5'd7, 1'b0, 32'h120), 4'h0, 32'hCAFEF00D, 1, 0, 0};
`ifdef WB_UNALIGNED_LOAD_EN
    vecs[9]  = '{mk(3'd5, 2'd1, 32'hAABBCCDD, 32'h0, 5'd10, 1'b1, 32'h124), 4'hC, 32'hCCDD0000, 1, 1, 1};
    vecs[10] = '{mk(3'd6, 2'd2, 32'hAABBCCDD, 32'h0, 5'd11, 1'b1, 32'h128), 4'h3, 32'h0000AABB, 1, 1, 1};
`else
    vecs[9]  = '{mk(3'd5, 2'd1, 32'hAABBCCDD, 32'h0, 5'd10, 1'b1, 32'h124), 4'h0, 32'h0, 0, 1, 0};
    vecs[10] = '{mk(3'd6, 2'd2, 32'hAABBCCDD, 32'h0, 5'd11, 1'b1, 32'h128), 4'h0, 32'h0, 0, 1, 0};
`endif

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].in);
      step();
      drive(1'b0, idle);
      #1;
      chk($sformatf("vec%0d_we", i), {28'h0, rf_we}, {28'h0, vecs[i].exp_we});
      chk($sformatf("vec%0d_waddr", i), {27'h0, rf_waddr}, {27'h0, vecs[i].in.dest});
      if (vecs[i].chk_data) chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].exp_data);
      chk($sformatf("vec%0d_fwd", i), {30'h0, ws_fwd_valid, ws_fwd_partial},
          {30'h0, vecs[i].exp_fv, vecs[i].exp_part});
      chk($sformatf("vec%0d_pc", i), debug_wb_pc, vecs[i].in.pc);
      step();
    end

    // Stall three cycles with the next instruction waiting upstream.
    a = mk(3'd7, 2'd0, 32'h0, 32'hA0A0A0A0, 5'd3, 1'b1, 32'h200);
    b = mk(3'd7, 2'd0, 32'h0, 32'hB0B0B0B0, 5'd4, 1'b1, 32'h204);
    drive(1'b1, a);
    step();
    ws_stall = 1'b1;
    drive(1'b1, b);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_we", k), {28'h0, rf_we}, 32'h0);
      chk($sformatf("stall%0d_allowin", k), {31'h0, ws_allowin}, 32'h0);
      chk($sformatf("stall%0d_fwd", k), {31'h0, ws_fwd_valid}, 32'h1);
      step();
    end
    ws_stall = 1'b0;
    #1;
    chk("release_we", {28'h0, rf_we}, 32'hF);
    chk("release_waddr", {27'h0, rf_waddr}, 32'd3);
    chk("release_wdata", rf_wdata, 32'hA0A0A0A0);
    chk("release_allowin", {31'h0, ws_allowin}, 32'h1);
    step();
    drive(1'b0, idle);
    #1;
    chk("next_waddr", {27'h0, rf_waddr}, 32'd4);
    chk("next_wdata", rf_wdata, 32'hB0B0B0B0);
    chk("next_we", {28'h0, rf_we}, 32'hF);
    step();
    #1;
    chk("drained_we", {28'h0, rf_we}, 32'h0);

    // Flush coincident with an offer: the offer is dropped.
    @(negedge clk);
    ws_flush = 1'b1;
    drive(1'b1, mk(3'd7, 2'd0, 32'h0, 32'h99, 5'd9, 1'b1, 32'h300));
    step();
    ws_flush = 1'b0;
    drive(1'b0, idle);
    #1;
    chk("flush_we", {28'h0, rf_we}, 32'h0);
    chk("flush_fwd", {31'h0, ws_fwd_valid}, 32'h0);

    // Flush while stalled holding a valid instruction: the older one survives.
    @(negedge clk);
    drive(1'b1, a);
    step();
    ws_stall = 1'b1; ws_flush = 1'b1;
    drive(1'b1, b);
    step();
    ws_stall = 1'b0; ws_flush = 1'b0;
    drive(1'b0, idle);
    #1;
    chk("flushstall_we", {28'h0, rf_we}, 32'hF);
    chk("flushstall_waddr", {27'h0, rf_waddr}, 32'd3);
    step();

    // Reset asserted mid-stall clears everything without waiting for a clock.
    drive(1'b1, mk(3'd7, 2'd0, 32'h0, 32'h5555AAAA, 5'd12, 1'b1, 32'h400));
    step();
    drive(1'b0, idle);
    ws_stall = 1'b1;
    #1;
    chk("prerst_fwd", {31'h0, ws_fwd_valid}, 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_fwd", {31'h0, ws_fwd_valid}, 32'h0);
    chk("midrst_fdata", ws_fwd_data, 32'h0);
    chk("midrst_fdest", {27'h0, ws_fwd_dest}, 32'h0);
    chk("midrst_we", {28'h0, rf_we}, 32'h0);
    chk("midrst_allowin", {31'h0, ws_allowin}, 32'h1);
    ws_stall = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    // Randomized traffic against the transaction-level model.
    m_valid = 1'b0;
    m_cur = mk(3'd0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    for (int c = 0; c < 400; c++) begin
      ins_t x;
      logic [3:0] mask, e_we;
      logic [31:0] data;
      bit known;
      logic e_allow, e_fv;
      @(negedge clk);
      x = mk(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom,
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), $urandom);
      drive(1'($urandom_range(0, 9) < 7), x);
      ws_stall = ($urandom_range(0, 3) == 0);
      ws_flush = ($urandom_range(0, 9) == 0);
      #1;
      ref_load(m_cur, mask, data, known);
      e_allow = !m_valid || !ws_stall;
      e_fv    = m_valid && m_cur.gr_we && (m_cur.dest != 0);
      e_we    = (e_fv && !ws_stall) ? mask : 4'h0;
      chk("rnd_allowin", {31'h0, ws_allowin}, {31'h0, e_allow});
      chk("rnd_we", {28'h0, rf_we}, {28'h0, e_we});
      chk("rnd_waddr", {27'h0, rf_waddr}, {27'h0, m_cur.dest});
      chk("rnd_fwd", {26'h0, ws_fwd_dest, ws_fwd_valid},
          {26'h0, m_cur.dest, e_fv});
      chk("rnd_partial", {31'h0, ws_fwd_partial}, {31'h0, e_fv && (mask != 4'hF) && known});
      chk("rnd_pc", debug_wb_pc, m_cur.pc);
      if (known) begin
        chk("rnd_wdata", rf_wdata, data);
        chk("rnd_fdata", ws_fwd_data, data);
      end
      @(posedge clk);
      if (ms_to_ws_valid && e_allow && !ws_flush) begin
        m_valid = 1'b1;
        m_cur = x;
      end else if (!ws_stall) begin
        m_valid = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
